// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2 -- iterative radix-2 restoring divider for MIPS DIV/DIVU (EX stage)
//
// Produces one quotient bit per cycle, MSB first, with a fixed latency.
// ready pulses for one cycle when the result is valid, and the hazard unit uses
// it to release the E/D stall. The result drives the HI/LO write path as
// {hi = remainder, lo = quotient}.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   start       in   level; a DIV/DIVU is present in E (sampled only in IDLE)
//   signed_div  in   1 = DIV (two's complement), 0 = DIVU
//   annul       in   flush/exception; abandon the current op at the next edge
//   a, b        in   dividend / divisor
//   ready       out  single-cycle result-valid pulse
//   result      out  {remainder, quotient}; held until the next op completes
// -----------------------------------------------------------------------------
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_rem, r_quo, r_div;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q, r_neg_r;

   logic             w_accept, w_last;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH+1:0] w_sub;
   logic             w_borrow;
   logic [WIDTH-1:0] w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;

   // annul has priority over start, so a flushed instruction is never accepted
   assign w_accept = (r_state == S_IDLE) && start && !annul;
   assign w_last   = (r_state == S_BUSY) && !annul && (r_cnt == LAST);

   // Magnitudes; -x wraps for the most negative value, which is what the
   // unsigned core needs (0x80000000 is its own magnitude)
   assign w_abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
   assign w_abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

   // Shifted partial remainder needs one extra bit before the trial subtract;
   // the extra top bit of w_sub is the borrow.
   assign w_sh     = {r_rem, r_quo[WIDTH-1]};
   assign w_sub    = {1'b0, w_sh} - {2'b00, r_div};
   assign w_borrow = w_sub[WIDTH+1];
   assign w_rem_nx = w_borrow ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_borrow};

   // Sign fixup applied to the final iteration's values as they are registered
   assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
   assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (start)               w_state_nx = S_BUSY;
         S_BUSY:  if (r_cnt == LAST)       w_state_nx = S_DONE;
         S_DONE:                           w_state_nx = S_IDLE;
         default:                          w_state_nx = S_IDLE;
      endcase
      if (annul) w_state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         result   <= '0;
      end else if (w_accept) begin
         r_rem    <= '0;
         r_quo    <= w_abs_a;
         r_div    <= w_abs_b;
         r_cnt    <= '0;
         r_neg_q  <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_neg_r  <= signed_div && a[WIDTH-1];
      end else if ((r_state == S_BUSY) && !annul) begin
         r_rem    <= w_rem_nx;
         r_quo    <= w_quo_nx;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) result <= {w_rem_fix, w_quo_fix};
      end
   end

   assign ready = (r_state == S_DONE);

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: hand-computed vectors, latency/pulse checks,
// back-to-back issue, annul and mid-op reset, plus a small signed/unsigned
// sweep against a behavioural reference.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, signed_div, annul;
   logic [31:0] a, b;
   logic        ready;
   logic [63:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   div_radix2 #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
      .annul(annul), .a(a), .b(b), .ready(ready), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Behavioural reference: returns {remainder, quotient}
   function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] q, r;
      if (y == 32'd0) begin
         r = x;
         q = (sg && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sg) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
      return {r, q};
   endfunction

   // Count edges until ready is seen (sampled 1 time unit after each edge)
   task automatic wait_ready(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!ready && cyc < 80);
   endtask

   task automatic no_ready(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (ready) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   task automatic do_div(input string tag, input logic sg, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
      int cyc;
      @(negedge clk);
      signed_div = sg; a = x; b = y; start = 1'b1;
      wait_ready(cyc);
      chk({tag, " latency"}, 64'(cyc), 64'd33);
      chk(tag, result, exp);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, " pulse"}, {63'd0, ready}, 64'd0);
      chk({tag, " hold"}, result, exp);
   endtask

   logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd3};

   initial begin
      int cyc;
      logic [63:0] prev;
      logic [31:0] x, y;
      logic        sg;

      resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
      a = '0; b = '0;
      #12;
      chk("reset ready", {63'd0, ready}, 64'd0);
      chk("reset result", result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      // directed vectors
      do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
      do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
      do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      do_div("divu 5/0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});

      // back-to-back with start held high throughout
      @(negedge clk);
      signed_div = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1;
      wait_ready(cyc);
      chk("b2b first latency", 64'(cyc), 64'd33);
      chk("b2b first", result, {32'd0, 32'd3});
      @(negedge clk);
      a = 32'd10; b = 32'd4;
      wait_ready(cyc);
      chk("b2b second spacing", 64'(cyc), 64'd34);
      chk("b2b second", result, {32'd2, 32'd2});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;

      // annul during BUSY: no pulse, result untouched
      prev = result;
      @(negedge clk);
      a = 32'd50; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      no_ready("annul no ready", 40);
      chk("annul result held", result, prev);

      // annul beats start in IDLE
      @(negedge clk);
      start = 1'b1; annul = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0; annul = 1'b0;
      no_ready("annul over start", 40);
      do_div("after annul", 1'b0, 32'd50, 32'd3, {32'd2, 32'd16});

      // reset asserted mid-BUSY
      @(negedge clk);
      a = 32'd1000; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("midreset ready", {63'd0, ready}, 64'd0);
      chk("midreset result", result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      no_ready("midreset no ready", 40);
      do_div("after reset", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111});

      // sweep: corner operands in both modes, then random
      for (int i = 0; i < 6; i++) begin
         sg = i[0];
         x  = specials[i];
         y  = specials[5 - i];
         do_div($sformatf("sweep corner %0d", i), sg, x, y, ref_div(sg, x, y));
      end
      for (int i = 0; i < 8; i++) begin
         sg = i[0];
         x  = $urandom;
         y  = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i == 6) y = -y;
         do_div($sformatf("sweep rand %0d", i), sg, x, y, ref_div(sg, x, y));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
